bypass_queue: RTL and testbench

Parametrised bypass FIFO for AXI-Stream-style valid/ready pipelines: a DEPTH-entry ring buffer that, when empty and in bypass mode, forwards pre-stage data to the post-stage in the same cycle. It decouples back-pressure so that ready_pre_o never depends combinationally on ready_post_i. It is the drop-in generalisation of the team's single-entry skid buffer for header-insert and width-conversion paths that need more than one beat of slack.

---
 rtl/stream_pkg.sv | 22 ++
 rtl/bypass_queue_if.sv | 39 +++
 rtl/bypass_queue_mem.sv | 40 ++++
 rtl/bypass_queue.sv | 117 +++++++++++
 tb/tb_bypass_queue.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_pkg
//  Description : Shared helpers for valid/ready stream blocks. Provides the
//                pointer-width function for wrap-bit ring buffers and the
//                depth legality test used by elaboration checks.
//  Revision    : 1.0  initial release
// ============================================================================
package stream_pkg;

    // Ring-buffer pointer width: address bits plus one wrap bit.
    function automatic int ptr_wd(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // A wrap-bit ring buffer needs a power-of-two depth of at least two.
    function automatic bit depth_legal(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage : stream_pkg
`default_nettype wire

// File: rtl/bypass_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : bypass_queue_if
//  Description : Pre-stage / post-stage valid/ready handshake bundle.
//                slave  : the queue side (accepts pre, produces post)
//                master : the environment side (drives pre, consumes post)
//  Ports       : valid_pre_i, data_pre_i, ready_pre_o   pre-stage handshake
//                valid_post_o, data_post_o, ready_post_i post-stage handshake
//  Revision    : 1.0  initial release
// ============================================================================
interface bypass_queue_if #(
    parameter int DATA_WD = 32
);
    logic               valid_pre_i;
    logic [DATA_WD-1:0] data_pre_i;
    logic               ready_pre_o;
    logic               valid_post_o;
    logic [DATA_WD-1:0] data_post_o;
    logic               ready_post_i;

    modport slave (
        input  valid_pre_i,
        input  data_pre_i,
        input  ready_post_i,
        output ready_pre_o,
        output valid_post_o,
        output data_post_o
    );

    modport master (
        output valid_pre_i,
        output data_pre_i,
        output ready_post_i,
        input  ready_pre_o,
        input  valid_post_o,
        input  data_post_o
    );
endinterface : bypass_queue_if
`default_nettype wire

// File: rtl/bypass_queue_mem.sv
`default_nettype none
// ============================================================================
//  Module      : bypass_queue_mem
//  Description : DATA_WD x DEPTH register array for bypass_queue. One
//                synchronous write port, one asynchronous read port. The data
//                array carries no reset.
//  Ports       : clk        clock
//                i_wr_en    write strobe
//                i_wr_addr  write address
//                i_wr_data  write data
//                i_rd_addr  read address
//                o_rd_data  read data (combinational from i_rd_addr)
//  Revision    : 1.0  initial release
// ============================================================================
module bypass_queue_mem
    import stream_pkg::*;
#(
    parameter int DATA_WD = 32,
    parameter int DEPTH   = 4
) (
    input  wire logic                          clk,
    input  wire logic                          i_wr_en,
    input  wire logic [ptr_wd(DEPTH)-2:0]      i_wr_addr,
    input  wire logic [DATA_WD-1:0]            i_wr_data,
    input  wire logic [ptr_wd(DEPTH)-2:0]      i_rd_addr,
    output logic      [DATA_WD-1:0]            o_rd_data
);

    logic [DATA_WD-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : bypass_queue_mem
`default_nettype wire

// File: rtl/bypass_queue.sv
`default_nettype none
// ============================================================================
//  Module      : bypass_queue
//  Description : DEPTH-entry bypass FIFO for valid/ready pipelines. When the
//                ring buffer is empty and BYPASS=1, pre-stage data is forwarded
//                to the post-stage in the same cycle. ready_pre_o depends only
//                on registered state, flush_i and rst, never on ready_post_i.
//  Ports       : clk      clock, rising edge
//                rst      asynchronous active-high reset
//                flush_i  synchronous clear of all stored entries
//                stream   pre/post handshake bundle (slave modport)
//                count_o  entries held in storage (bypassed beats excluded)
//  Revision    : 1.0  initial release
// ============================================================================
module bypass_queue
    import stream_pkg::*;
#(
    parameter int DATA_WD = 32,
    parameter int DEPTH   = 4,
    parameter int BYPASS  = 1,
    parameter int CNT_WD  = $clog2(DEPTH + 1)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              flush_i,
    bypass_queue_if.slave          stream,
    output logic      [CNT_WD-1:0] count_o
);

    localparam int c_ptr_wd  = ptr_wd(DEPTH);
    localparam int c_addr_wd = c_ptr_wd - 1;

    // Elaboration-time guard against illegal depths or an overridden CNT_WD.
    generate
        if (!depth_legal(DEPTH)) begin : g_bad_depth
            $error("bypass_queue: DEPTH must be a power of two and >= 2");
        end
        if (CNT_WD != c_ptr_wd) begin : g_bad_cnt_wd
            $error("bypass_queue: CNT_WD is derived and must not be overridden");
        end
    endgenerate

    logic [c_ptr_wd-1:0] r_wr_ptr;
    logic [c_ptr_wd-1:0] r_rd_ptr;
    logic [c_ptr_wd-1:0] w_occupancy;
    logic [DATA_WD-1:0]  w_rd_data;
    logic                w_empty;
    logic                w_full;
    logic                w_bypass;
    logic                w_ready_pre;
    logic                w_valid_post;
    logic                w_enq;
    logic                w_deq;
    logic                w_wr_en;
    logic                w_rd_en;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_addr_wd-1:0] == r_rd_ptr[c_addr_wd-1:0]) &&
                     (r_wr_ptr[c_addr_wd] != r_rd_ptr[c_addr_wd]);

    // Bypass is only ever taken from an empty queue, so it cannot overtake
    // stored beats.
    assign w_bypass = (BYPASS != 0) && w_empty;

    assign w_ready_pre  = !w_full && !flush_i && !rst;
    assign w_valid_post = !flush_i && !rst &&
                          (w_bypass ? stream.valid_pre_i : !w_empty);

    assign w_enq = stream.valid_pre_i && w_ready_pre;
    assign w_deq = w_valid_post && stream.ready_post_i;

    // A bypassed beat that the post-stage takes immediately never touches
    // storage; any other accepted beat is written.
    assign w_wr_en = w_enq && !(w_bypass && stream.ready_post_i);
    // In bypass the post-stage reads the pre-stage, not storage.
    assign w_rd_en = w_deq && !w_bypass;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    bypass_queue_mem #(
        .DATA_WD (DATA_WD),
        .DEPTH   (DEPTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr[c_addr_wd-1:0]),
        .i_wr_data (stream.data_pre_i),
        .i_rd_addr (r_rd_ptr[c_addr_wd-1:0]),
        .o_rd_data (w_rd_data)
    );

    // Wrap-bit pointers make the modular difference the exact occupancy,
    // 0..DEPTH inclusive.
    assign w_occupancy = r_wr_ptr - r_rd_ptr;
    assign count_o     = CNT_WD'(w_occupancy);

    assign stream.ready_pre_o  = w_ready_pre;
    assign stream.valid_post_o = w_valid_post;
    assign stream.data_post_o  = w_bypass ? stream.data_pre_i : w_rd_data;

endmodule : bypass_queue
`default_nettype wire

// File: tb/tb_bypass_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bypass_queue
//  Description : Self-checking bench for bypass_queue. Two instances with
//                DEPTH=4: u_dut1 (BYPASS=1) and u_dut0 (BYPASS=0). Inputs are
//                driven on the falling edge, outputs sampled 1 ns before the
//                rising edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bypass_queue;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [2:0] cnt1;
    logic [2:0] cnt0;

    int n_cmp = 0;
    int n_err = 0;
    int n_del1 = 0;
    int n_del0 = 0;

    logic [31:0] sb1[$];
    logic [31:0] sb0[$];

    bypass_queue_if #(.DATA_WD(32)) q1 ();
    bypass_queue_if #(.DATA_WD(32)) q0 ();

    bypass_queue #(.DATA_WD(32), .DEPTH(DEPTH), .BYPASS(1)) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .stream  (q1),
        .count_o (cnt1)
    );

    bypass_queue #(.DATA_WD(32), .DEPTH(DEPTH), .BYPASS(0)) u_dut0 (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .stream  (q0),
        .count_o (cnt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        fl;
        logic        v;
        logic [31:0] d;
        logic        r;
        logic        e_rdy;
        logic        e_vld;
        logic [31:0] e_d;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(input logic fl, input logic v, input logic [31:0] d,
                                input logic r, input logic e_rdy, input logic e_vld,
                                input logic [31:0] e_d, input logic [2:0] e_cnt);
        return {fl, v, d, r, e_rdy, e_vld, e_d, e_cnt};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: the queue holds every accepted, undelivered beat.
    task automatic check_cycle(input int which, input logic fl, input logic byp,
                               input logic vin, input logic [31:0] din, input logic rin,
                               input logic rdy, input logic vout, input logic [31:0] dout,
                               input logic [2:0] cnt);
        int          occ;
        logic        exp_rdy;
        logic        exp_vout;
        logic [31:0] front;
        occ      = (which != 0) ? sb1.size() : sb0.size();
        exp_rdy  = (occ != DEPTH) && !fl;
        exp_vout = !fl && ((occ != 0) || (byp && vin));
        front    = (occ == 0) ? din : ((which != 0) ? sb1[0] : sb0[0]);
        chk((which != 0) ? "count1" : "count0", {29'd0, cnt}, occ);
        chk("count_bound", {31'd0, (cnt <= 3'(DEPTH))}, 32'd1);
        chk((which != 0) ? "ready_pre1" : "ready_pre0", {31'd0, rdy}, {31'd0, exp_rdy});
        chk((which != 0) ? "valid_post1" : "valid_post0", {31'd0, vout}, {31'd0, exp_vout});
        if (exp_vout) begin
            chk((which != 0) ? "data_post1" : "data_post0", dout, front);
        end
        if (vin && exp_rdy) begin
            if (which != 0) sb1.push_back(din);
            else            sb0.push_back(din);
        end
        if (exp_vout && rin) begin
            if (which != 0) begin
                void'(sb1.pop_front());
                n_del1++;
            end else begin
                void'(sb0.pop_front());
                n_del0++;
            end
        end
        if (fl) begin
            if (which != 0) sb1.delete();
            else            sb0.delete();
        end
    endtask

    task automatic cyc(input logic fl,
                       input logic v1, input logic [31:0] d1, input logic r1,
                       input logic v0, input logic [31:0] d0, input logic r0,
                       input bit use_model);
        @(negedge clk);
        flush           = fl;
        q1.valid_pre_i  = v1;
        q1.data_pre_i   = d1;
        q1.ready_post_i = r1;
        q0.valid_pre_i  = v0;
        q0.data_pre_i   = d0;
        q0.ready_post_i = r0;
        #4;
        if (use_model) begin
            check_cycle(1, fl, 1'b1, v1, d1, r1, q1.ready_pre_o, q1.valid_post_o, q1.data_post_o, cnt1);
            check_cycle(0, fl, 1'b0, v0, d0, r0, q0.ready_pre_o, q0.valid_post_o, q0.data_post_o, cnt0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_count1"},      {29'd0, cnt1}, 32'd0);
        chk({tag, "_count0"},      {29'd0, cnt0}, 32'd0);
        chk({tag, "_ready_pre1"},  {31'd0, q1.ready_pre_o}, 32'd0);
        chk({tag, "_ready_pre0"},  {31'd0, q0.ready_pre_o}, 32'd0);
        chk({tag, "_valid_post1"}, {31'd0, q1.valid_post_o}, 32'd0);
        chk({tag, "_valid_post0"}, {31'd0, q0.valid_post_o}, 32'd0);
    endtask

    initial begin
        int ncyc;

        // Directed BYPASS=1 sequence: bypass, fill, full, drain, flush.
        //             fl  v   d       r   rdy vld e_d     cnt
        tbl[0]  = mk(0, 0, 32'h0,  1, 1, 0, 32'h0,  0);
        tbl[1]  = mk(0, 1, 32'h01, 1, 1, 1, 32'h01, 0);
        tbl[2]  = mk(0, 1, 32'h02, 1, 1, 1, 32'h02, 0);
        tbl[3]  = mk(0, 1, 32'hA0, 0, 1, 1, 32'hA0, 0);
        tbl[4]  = mk(0, 1, 32'hA1, 0, 1, 1, 32'hA0, 1);
        tbl[5]  = mk(0, 1, 32'hA2, 0, 1, 1, 32'hA0, 2);
        tbl[6]  = mk(0, 1, 32'hA3, 0, 1, 1, 32'hA0, 3);
        tbl[7]  = mk(0, 1, 32'hA4, 0, 0, 1, 32'hA0, 4);
        tbl[8]  = mk(0, 1, 32'hA4, 1, 0, 1, 32'hA0, 4);
        tbl[9]  = mk(0, 1, 32'hA4, 1, 1, 1, 32'hA1, 3);
        tbl[10] = mk(0, 0, 32'h0,  1, 1, 1, 32'hA2, 3);
        tbl[11] = mk(0, 0, 32'h0,  1, 1, 1, 32'hA3, 2);
        tbl[12] = mk(0, 0, 32'h0,  1, 1, 1, 32'hA4, 1);
        tbl[13] = mk(0, 0, 32'h0,  0, 1, 0, 32'h0,  0);
        tbl[14] = mk(0, 1, 32'hB0, 0, 1, 1, 32'hB0, 0);
        tbl[15] = mk(0, 1, 32'hB1, 0, 1, 1, 32'hB0, 1);
        tbl[16] = mk(0, 1, 32'hB2, 0, 1, 1, 32'hB0, 2);
        tbl[17] = mk(1, 1, 32'hB3, 1, 0, 0, 32'h0,  3);
        tbl[18] = mk(0, 1, 32'hC0, 0, 1, 1, 32'hC0, 0);
        tbl[19] = mk(0, 0, 32'h0,  1, 1, 1, 32'hC0, 1);
        tbl[20] = mk(0, 0, 32'h0,  1, 1, 0, 32'h0,  0);

        // Reset state, with valid_pre high to show bypass is gated by rst.
        rst             = 1'b1;
        flush           = 1'b0;
        q1.valid_pre_i  = 1'b1;
        q1.data_pre_i   = 32'hDEAD;
        q1.ready_post_i = 1'b1;
        q0.valid_pre_i  = 1'b1;
        q0.data_pre_i   = 32'hDEAD;
        q0.ready_post_i = 1'b1;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            cyc(tbl[i].fl, tbl[i].v, tbl[i].d, tbl[i].r, 1'b0, 32'h0, 1'b0, 1'b0);
            chk($sformatf("tbl%0d_count", i), {29'd0, cnt1}, {29'd0, tbl[i].e_cnt});
            chk($sformatf("tbl%0d_ready_pre", i), {31'd0, q1.ready_pre_o}, {31'd0, tbl[i].e_rdy});
            chk($sformatf("tbl%0d_valid_post", i), {31'd0, q1.valid_post_o}, {31'd0, tbl[i].e_vld});
            if (tbl[i].e_vld) begin
                chk($sformatf("tbl%0d_data_post", i), q1.data_post_o, tbl[i].e_d);
            end
        end

        // Back-to-back stream 0x1..0x10 with post always ready.
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 1'b1, 32'(i), 1'b1, 1'b1, 32'(i), 1'b1, 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        end

        // Registered-mode latency: single 0x55 beat.
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h55, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1);

        // Asynchronous reset mid-burst with two beats stored.
        cyc(1'b0, 1'b1, 32'hE0, 1'b0, 1'b1, 32'hF0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 32'hE1, 1'b0, 1'b1, 32'hF1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  1'b0, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        sb1.delete();
        sb0.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        end

        // Random traffic with occasional flush until both see 10,000 beats.
        n_del1 = 0;
        n_del0 = 0;
        ncyc   = 0;
        while (((n_del1 < 10000) || (n_del0 < 10000)) && (ncyc < 40000)) begin
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 3) != 0),
                1'b1);
            ncyc++;
        end
        chk("random_budget", {31'd0, (ncyc < 40000)}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_bypass_queue
`default_nettype wire
